// File: rtl/microwave_control.sv
// Microwave cook sequencer: keypad digit loading, 1 Hz prescaler, cook/pause/done FSM.
// Optional one-touch 0:30 quick start is enabled by defining QUICK_START_EN.
module microwave_control #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int DONE_CYCLES   = 100000000
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clearn,
  output logic       timer_en,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state_o
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int DW = $clog2(DONE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4,
    S_QLOAD = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    data_q, data_d;
  logic          loadn_q, loadn_d;
  logic          clearn_q, clearn_d;
  logic          en_q, en_d;
  logic          mag_q, mag_d;
  logic          done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic key_ok;
  logic start_ok;

  assign key_ok   = key_valid && (key_digit <= 4'd9);
  // While a load pulse is in flight timer_zero still reflects the old digits.
  assign start_ok = start && loadn_q;

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    loadn_d  = 1'b1;
    clearn_d = 1'b1;
    en_d     = 1'b0;
    mag_d    = 1'b0;
    done_d   = 1'b0;
    presc_d  = presc_q;
    dcnt_d   = dcnt_q;

    case (state_q)
      S_IDLE: begin
        if (key_ok) begin
          state_d = S_SETUP;
          loadn_d = 1'b0;
          data_d  = key_digit;
        end
`ifdef QUICK_START_EN
        else if (start_ok && door_closed && !stop) begin
          state_d = S_QLOAD;
          loadn_d = 1'b0;
          data_d  = 4'd3;
        end
`endif
      end

      S_SETUP: begin
        if (stop) begin
          state_d  = S_IDLE;
          clearn_d = 1'b0;
        end else if (key_ok) begin
          loadn_d = 1'b0;
          data_d  = key_digit;
        end else if (start_ok && door_closed && !timer_zero) begin
          state_d = S_COOK;
          mag_d   = 1'b1;
          presc_d = '0;
        end
      end

      S_COOK: begin
        if (!door_closed || stop) begin
          state_d = S_PAUSE;
        end else if (timer_zero) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          dcnt_d  = DW'(1);
        end else begin
          mag_d = 1'b1;
          if (presc_q == PRESC_LAST) begin
            en_d    = 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_d  = S_IDLE;
          clearn_d = 1'b0;
        end else if (start_ok && door_closed) begin
          state_d = S_COOK;
          mag_d   = 1'b1;
          presc_d = '0;
        end
      end

      S_DONE: begin
        if (stop || !door_closed || (dcnt_q == DONE_LAST)) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
        end else begin
          done_d = 1'b1;
          dcnt_d = dcnt_q + DW'(1);
        end
      end

`ifdef QUICK_START_EN
      S_QLOAD: begin
        if (stop || !door_closed) begin
          state_d  = S_IDLE;
          clearn_d = 1'b0;
        end else if (data_q == 4'd3) begin
          loadn_d = 1'b0;
          data_d  = 4'd0;
        end else begin
          // 0:30 is known non-zero, so no timer_zero check here.
          state_d = S_COOK;
          mag_d   = 1'b1;
          presc_d = '0;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      data_q   <= 4'd0;
      loadn_q  <= 1'b1;
      clearn_q <= 1'b0;
      en_q     <= 1'b0;
      mag_q    <= 1'b0;
      done_q   <= 1'b0;
      presc_q  <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      loadn_q  <= loadn_d;
      clearn_q <= clearn_d;
      en_q     <= en_d;
      mag_q    <= mag_d;
      done_q   <= done_d;
      presc_q  <= presc_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign timer_data   = data_q;
  assign timer_loadn  = loadn_q;
  assign timer_clearn = clearn_q;
  assign timer_en     = en_q;
  assign mag_on       = mag_q;
  assign done         = done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_microwave_control.sv
// Scoreboard bench for microwave_control: a behavioural model predicts every output change
// (with its cycle), a monitor compares each change the DUT makes against the queue.
module tb_microwave_control;

  localparam int T = 4;
  localparam int D = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_COOK  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_QLOAD = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] data;
    logic       loadn;
    logic       clearn;
    logic       en;
    logic       mag;
    logic       done;
  } outv_t;

  typedef struct {
    int    cyc;
    outv_t v;
  } ev_t;

  localparam outv_t RESET_V = '{st: 3'd0, data: 4'd0, loadn: 1'b1, clearn: 1'b0,
                                en: 1'b0, mag: 1'b0, done: 1'b0};

  logic       clock = 1'b0;
  logic       clear, key_valid, start, stop, door_closed;
  logic [3:0] key_digit;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn, timer_clearn, timer_en, mag_on, done;
  logic [2:0] state_o;

  microwave_control #(.TICKS_PER_SEC(T), .DONE_CYCLES(D)) dut (
    .clock(clock), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_data(timer_data), .timer_loadn(timer_loadn), .timer_clearn(timer_clearn),
    .timer_en(timer_en), .mag_on(mag_on), .done(done), .state_o(state_o)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  // Countdown timer the sequencer drives: three BCD digits, shift-load, m:ss decrement.
  logic [3:0] t_ones = 4'd0, t_tens = 4'd0, t_mins = 4'd0;
  assign timer_zero = (t_ones == 4'd0) && (t_tens == 4'd0) && (t_mins == 4'd0);

  always @(posedge clock) begin
    if (timer_clearn === 1'b0) begin
      t_ones <= 4'd0; t_tens <= 4'd0; t_mins <= 4'd0;
    end else if (timer_loadn === 1'b0) begin
      t_mins <= t_tens; t_tens <= t_ones; t_ones <= timer_data;
    end else if (timer_en === 1'b1) begin
      if (t_ones != 4'd0) t_ones <= t_ones - 4'd1;
      else if (t_tens != 4'd0) begin t_tens <= t_tens - 4'd1; t_ones <= 4'd9; end
      else if (t_mins != 4'd0) begin t_mins <= t_mins - 4'd1; t_tens <= 4'd5; t_ones <= 4'd9; end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, edge_n);
  endtask

  // ---------------- reference model ----------------
  ev_t   sb[$];
  outv_t m_out;
  int    m_secs[3];      // [0]=ones, [1]=tens, [2]=mins as the timer holds them
  int    m_cook_age;     // cycles spent cooking since the latest COOK entry
  int    m_done_age;     // cycles done has been shown

  function automatic bit m_zero();
    return (m_secs[0] == 0) && (m_secs[1] == 0) && (m_secs[2] == 0);
  endfunction

  task automatic m_count_down();
    int total;
    total = m_secs[2] * 60 + m_secs[1] * 10 + m_secs[0];
    if (total == 0) return;
    if (m_secs[0] > 0) m_secs[0]--;
    else if (m_secs[1] > 0) begin m_secs[1]--; m_secs[0] = 9; end
    else begin m_secs[2]--; m_secs[1] = 5; m_secs[0] = 9; end
  endtask

  // Called at each rising edge with the inputs the DUT samples there; predicts the next cycle.
  task automatic model_step();
    outv_t nx;
    bit zero, key_ok, go, cook_now;
    zero     = m_zero();
    key_ok   = key_valid && (key_digit < 4'd10);
    go       = start && m_out.loadn;
    cook_now = 1'b0;
    nx        = m_out;
    nx.loadn  = 1'b1;
    nx.clearn = 1'b1;
    nx.en     = 1'b0;
    nx.mag    = 1'b0;
    nx.done   = 1'b0;
    if (clear) begin
      nx = RESET_V;
      m_done_age = 0;
    end else begin
      case (m_out.st)
        ST_IDLE: begin
          if (key_ok) begin nx.st = ST_SETUP; nx.loadn = 1'b0; nx.data = key_digit; end
`ifdef QUICK_START_EN
          else if (go && door_closed && !stop) begin
            nx.st = ST_QLOAD; nx.loadn = 1'b0; nx.data = 4'd3;
          end
`endif
        end
        ST_SETUP: begin
          if (stop) begin nx.st = ST_IDLE; nx.clearn = 1'b0; end
          else if (key_ok) begin nx.loadn = 1'b0; nx.data = key_digit; end
          else if (go && door_closed && !zero) cook_now = 1'b1;
        end
        ST_COOK: begin
          if (!door_closed || stop) nx.st = ST_PAUSE;
          else if (zero) begin nx.st = ST_DONE; nx.done = 1'b1; m_done_age = 1; end
          else begin
            m_cook_age++;
            nx.mag = 1'b1;
            nx.en  = (m_cook_age % T) == 0;
          end
        end
        ST_PAUSE: begin
          if (stop) begin nx.st = ST_IDLE; nx.clearn = 1'b0; end
          else if (go && door_closed) cook_now = 1'b1;
        end
        ST_DONE: begin
          if (stop || !door_closed || m_done_age >= D) begin nx.st = ST_IDLE; m_done_age = 0; end
          else begin m_done_age++; nx.done = 1'b1; end
        end
        ST_QLOAD: begin
          if (stop || !door_closed) begin nx.st = ST_IDLE; nx.clearn = 1'b0; end
          else if (m_out.data == 4'd3) begin nx.loadn = 1'b0; nx.data = 4'd0; end
          else cook_now = 1'b1;
        end
        default: ;
      endcase
      if (cook_now) begin nx.st = ST_COOK; nx.mag = 1'b1; m_cook_age = 0; end
    end
    // The timer reacts to the strobes of the cycle now ending.
    if (!m_out.clearn) m_secs = '{0, 0, 0};
    else if (!m_out.loadn) begin
      m_secs[2] = m_secs[1]; m_secs[1] = m_secs[0]; m_secs[0] = int'(m_out.data);
    end else if (m_out.en) m_count_down();
    if (nx != m_out) sb.push_back('{edge_n + 1, nx});
    m_out = nx;
  endtask

  // ---------------- monitor ----------------
  outv_t dut_v, mon_prev;
  bit    mon_en = 1'b0;
  assign dut_v = {state_o, timer_data, timer_loadn, timer_clearn, timer_en, mag_on, done};

  always @(negedge clock) begin
    if (mon_en && (dut_v !== mon_prev)) begin
      ev_t e;
      check("event_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("event_cycle", edge_n, e.cyc);
        check("event_outputs", 32'(dut_v), 32'(e.v));
      end
      mon_prev <= dut_v;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; step(); key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; stop = 1'b0; door_closed = 1'b1;

    @(posedge clock); #1;
    check("reset_clearn_first", 32'(timer_clearn), 32'd0);
    @(posedge clock); #1;
    check("reset_state",  32'(state_o),      32'd0);
    check("reset_mag",    32'(mag_on),       32'd0);
    check("reset_done",   32'(done),         32'd0);
    check("reset_loadn",  32'(timer_loadn),  32'd1);
    check("reset_clearn", 32'(timer_clearn), 32'd0);
    check("reset_en",     32'(timer_en),     32'd0);
    check("reset_data",   32'(timer_data),   32'd0);

    clear = 1'b0;
    m_out = RESET_V; m_secs = '{0, 0, 0}; m_cook_age = 0; m_done_age = 0;
    mon_prev = dut_v;
    mon_en = 1'b1;

    // Entry 1,2 -> 0:12, full countdown, done, back to idle.
    idle(2);
    press(4'd1); press(4'd2); idle(1);
    pulse_start();
    idle(12 * T + D + 8);

    // Door interlock mid-cook, then resume.
    press(4'd3); idle(1); pulse_start(); idle(6);
    door_closed = 1'b0; idle(6);
    door_closed = 1'b1; idle(2);
    pulse_start(); idle(3 * T + D + 8);

    // Invalid key, cancel, zero-only entry.
    press(4'd11); idle(2);
    press(4'd5); idle(1); pulse_stop(); idle(2);
    press(4'd0); idle(1); pulse_start(); idle(3);
    pulse_stop(); idle(2);

    // start+stop together while paused.
    press(4'd2); idle(1); pulse_start(); idle(3);
    door_closed = 1'b0; step(); door_closed = 1'b1; idle(1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; idle(2);

    // start during the in-flight load is dropped.
    key_valid = 1'b1; key_digit = 4'd4; step(); key_valid = 1'b0;
    start = 1'b1; step(); start = 1'b0; idle(3);
    pulse_stop(); idle(2);

    // start in idle: quick start only when the feature is built in.
    pulse_start(); idle(3 * T + D + 10);
    pulse_stop(); idle(2);

    // Mid-cook clear.
    press(4'd7); idle(1); pulse_start(); idle(5);
    clear = 1'b1; step(); clear = 1'b0; idle(3);

    // Randomized operations.
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2: press(4'($urandom_range(0, 15)));
        3, 4:    pulse_start();
        5:       pulse_stop();
        6: begin door_closed = 1'b0; idle($urandom_range(1, 4)); door_closed = 1'b1; end
        7: begin start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; end
        8:       idle($urandom_range(1, 12));
        9:       if ($urandom_range(0, 7) == 0) begin clear = 1'b1; step(); clear = 1'b0; end
                 else idle(1);
        default: idle($urandom_range(10, 40));
      endcase
    end

    idle(4);
    @(negedge clock); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
